isa_io_arbiter: RTL and testbench

ISA_IO_ARBITER -- requirements
Module: isa_io_arbiter

---
 rtl/isa_pkg.sv | 23 ++
 rtl/isa_io_arbiter_if.sv | 39 +++
 rtl/rr_arb2.sv | 36 +++
 rtl/isa_io_arbiter.sv | 142 ++++++++++++++
 tb/tb_isa_io_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_pkg: shared widths, default strobe timing and FSM state encoding  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package isa_pkg;

  localparam int c_addr_w      = 10;
  localparam int c_data_w      = 8;
  localparam int c_cnt_w       = 4;
  localparam int c_setup_cyc   = 1;
  localparam int c_strobe_cyc  = 3;
  localparam int c_hold_cyc    = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/isa_io_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_io_arbiter_if: requester handshake plus ISA I/O bus bundle        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface isa_io_arbiter_if;
  import isa_pkg::*;

  logic [1:0]          req;
  logic [1:0]          we;
  logic [c_addr_w-1:0] addr0;
  logic [c_addr_w-1:0] addr1;
  logic [c_data_w-1:0] wdata0;
  logic [c_data_w-1:0] wdata1;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [c_data_w-1:0] rdata;
  logic [c_addr_w-1:0] SA;
  logic [c_data_w-1:0] SD_out;
  logic                SD_oe;
  logic [c_data_w-1:0] SD_in;
  logic                IOR;
  logic                IOW;
  logic                AEN;
  logic                busy;

  // master: requesters and the external bus side; slave: the arbiter
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, SD_in,
    input  gnt, done, rdata, SA, SD_out, SD_oe, IOR, IOW, AEN, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, SD_in,
    output gnt, done, rdata, SA, SD_out, SD_oe, IOR, IOW, AEN, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2: two-way round-robin grant, pointer moves only on accept      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] i_req,
  input  wire logic       i_accept,
  output logic      [1:0] o_gnt
);

  // set when requester 1 won last, giving requester 0 the next tie
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/isa_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_io_arbiter: shares one ISA I/O cycle engine between 2 requesters  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module isa_io_arbiter
  import isa_pkg::*;
#(
  parameter int SETUP_CYC  = c_setup_cyc,
  parameter int STROBE_CYC = c_strobe_cyc,
  parameter int HOLD_CYC   = c_hold_cyc
) (
  input wire logic        clk,
  input wire logic        rst_n,
  isa_io_arbiter_if.slave bus
);

  localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'(SETUP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_owner;
  logic                r_we;
  logic [c_addr_w-1:0] r_addr;
  logic [c_data_w-1:0] r_wdata;
  logic [c_data_w-1:0] r_rdata;
  logic [1:0]          w_win;
  logic [1:0]          w_owner_oh;
  logic                w_accept;
  logic                w_cnt_zero;

  assign w_accept   = (r_state == ST_IDLE) && (|w_win);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (bus.req),
    .i_accept (w_accept),
    .o_gnt    (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_next = ST_SETUP;
      ST_SETUP:  if (w_cnt_zero) w_next = ST_STROBE;
      ST_STROBE: if (w_cnt_zero) w_next = ST_HOLD;
      ST_HOLD:   if (w_cnt_zero) w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // one shared down-counter, reloaded whenever a new state is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      case (w_next)
        ST_SETUP:  r_cnt <= c_setup_ld;
        ST_STROBE: r_cnt <= c_strobe_ld;
        ST_HOLD:   r_cnt <= c_hold_ld;
        default:   r_cnt <= '0;
      endcase
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_win[1];
        r_we    <= w_win[1] ? bus.we[1] : bus.we[0];
        r_addr  <= w_win[1] ? bus.addr1 : bus.addr0;
        r_wdata <= w_win[1] ? bus.wdata1 : bus.wdata0;
      end
      if ((r_state == ST_STROBE) && w_cnt_zero && !r_we) begin
        r_rdata <= bus.SD_in;
      end
    end
  end

  always_comb begin
    bus.gnt   = 2'b00;
    bus.done  = 2'b00;
    bus.IOR   = 1'b1;
    bus.IOW   = 1'b1;
    bus.AEN   = 1'b1;
    bus.SD_oe = 1'b0;
    bus.busy  = 1'b0;
    case (r_state)
      ST_SETUP: begin
        bus.gnt   = w_owner_oh;
        bus.AEN   = 1'b0;
        bus.SD_oe = r_we;
        bus.busy  = 1'b1;
      end
      ST_STROBE: begin
        bus.gnt   = w_owner_oh;
        bus.AEN   = 1'b0;
        bus.SD_oe = r_we;
        bus.busy  = 1'b1;
        bus.IOR   = r_we;
        bus.IOW   = !r_we;
      end
      ST_HOLD: begin
        bus.gnt   = w_owner_oh;
        bus.AEN   = 1'b0;
        bus.SD_oe = r_we;
        bus.busy  = 1'b1;
        bus.done  = w_cnt_zero ? w_owner_oh : 2'b00;
      end
      default: ;
    endcase
  end

  // address and write data stay parked on the bus between cycles
  assign bus.SA     = r_addr;
  assign bus.SD_out = r_wdata;
  assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_isa_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_isa_io_arbiter: scoreboard bench, default and 2/1/3 timing copies  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_isa_io_arbiter;

  typedef struct {
    int         dut;
    int         owner;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] sdin;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] req_v [2];
  logic [1:0] we_v  [2];
  logic [9:0] a0_v  [2];
  logic [9:0] a1_v  [2];
  logic [7:0] w0_v  [2];
  logic [7:0] w1_v  [2];
  logic [7:0] sdin_v[2];

  wire [1:0] gnt_w  [2];
  wire [1:0] done_w [2];
  wire [7:0] rdata_w[2];
  wire [7:0] sdout_w[2];
  wire [9:0] sa_w   [2];
  wire       oe_w   [2];
  wire       ior_w  [2];
  wire       iow_w  [2];
  wire       aen_w  [2];
  wire       busy_w [2];

  isa_io_arbiter_if bus0 ();
  isa_io_arbiter_if bus1 ();

  assign bus0.req = req_v[0]; assign bus0.we = we_v[0]; assign bus0.SD_in = sdin_v[0];
  assign bus0.addr0 = a0_v[0]; assign bus0.addr1 = a1_v[0];
  assign bus0.wdata0 = w0_v[0]; assign bus0.wdata1 = w1_v[0];
  assign bus1.req = req_v[1]; assign bus1.we = we_v[1]; assign bus1.SD_in = sdin_v[1];
  assign bus1.addr0 = a0_v[1]; assign bus1.addr1 = a1_v[1];
  assign bus1.wdata0 = w0_v[1]; assign bus1.wdata1 = w1_v[1];

  assign gnt_w[0] = bus0.gnt;   assign done_w[0] = bus0.done; assign rdata_w[0] = bus0.rdata;
  assign sdout_w[0] = bus0.SD_out; assign sa_w[0] = bus0.SA; assign oe_w[0] = bus0.SD_oe;
  assign ior_w[0] = bus0.IOR;   assign iow_w[0] = bus0.IOW;   assign aen_w[0] = bus0.AEN;
  assign busy_w[0] = bus0.busy;
  assign gnt_w[1] = bus1.gnt;   assign done_w[1] = bus1.done; assign rdata_w[1] = bus1.rdata;
  assign sdout_w[1] = bus1.SD_out; assign sa_w[1] = bus1.SA; assign oe_w[1] = bus1.SD_oe;
  assign ior_w[1] = bus1.IOR;   assign iow_w[1] = bus1.IOW;   assign aen_w[1] = bus1.AEN;
  assign busy_w[1] = bus1.busy;

  isa_io_arbiter u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  isa_io_arbiter #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int   busy_cnt  [2];
  int   strobe_cnt[2];
  logic [7:0] last_rd[2];

  function automatic int busy_total(input int d);
    return (d == 0) ? (1 + 3 + 1) : (2 + 1 + 3);
  endfunction

  function automatic int strobe_len(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input int owner, input logic we,
                          input logic [9:0] addr, input logic [7:0] wdata, input logic [7:0] sdin);
    exp_t e;
    e.dut = d; e.owner = owner; e.we = we; e.addr = addr; e.wdata = wdata; e.sdin = sdin;
    sbq.push_back(e);
  endtask

  task automatic set_req(input int d, input int r, input logic we,
                         input logic [9:0] addr, input logic [7:0] wdata);
    if (r == 0) begin a0_v[d] = addr; w0_v[d] = wdata; end
    else        begin a1_v[d] = addr; w1_v[d] = wdata; end
    we_v[d][r]  = we;
    req_v[d][r] = 1'b1;
  endtask

  task automatic wait_done(input int d, input int lat, output logic [1:0] seen);
    int n;
    seen = 2'b00;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done_w[d] != 2'b00) begin
        seen = done_w[d];
        break;
      end
    end
    if (seen == 2'b00) chk("done_timeout", 0, 1);
    else               chk("done_latency", n, lat);
  endtask

  task automatic wait_strobe(input int d);
    int n;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!ior_w[d] || !iow_w[d]) break;
    end
    if (n > 200) chk("strobe_timeout", 0, 1);
  endtask

  task automatic check_reset(input int d);
    chk("rst_gnt",   gnt_w[d],   0);
    chk("rst_done",  done_w[d],  0);
    chk("rst_rdata", rdata_w[d], 0);
    chk("rst_sa",    sa_w[d],    0);
    chk("rst_sdout", sdout_w[d], 0);
    chk("rst_sdoe",  oe_w[d],    0);
    chk("rst_ior",   ior_w[d],   1);
    chk("rst_iow",   iow_w[d],   1);
    chk("rst_aen",   aen_w[d],   1);
    chk("rst_busy",  busy_w[d],  0);
  endtask

  // bus monitor: checks every active cycle against the front of the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        busy_cnt[d] = 0; strobe_cnt[d] = 0; last_rd[d] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (busy_w[d]) begin
          busy_cnt[d]++;
          if (!ior_w[d] || !iow_w[d]) strobe_cnt[d]++;
          if (sbq.size() == 0) begin
            chk("busy_without_txn", 1, 0);
          end else begin
            mon_e = sbq[0];
            chk("txn_dut", d, mon_e.dut);
            chk("gnt", gnt_w[d], mon_e.owner ? 2'b10 : 2'b01);
            chk("aen_active", aen_w[d], 0);
            chk("sa", sa_w[d], mon_e.addr);
            chk("sd_oe", oe_w[d], mon_e.we);
            if (mon_e.we) chk("sd_out", sdout_w[d], mon_e.wdata);
            if (!ior_w[d] || !iow_w[d])
              chk("strobe_dir", {ior_w[d], iow_w[d]}, mon_e.we ? 2'b10 : 2'b01);
          end
        end else begin
          chk("idle_bus", {gnt_w[d], aen_w[d], ior_w[d], iow_w[d]}, 5'b00111);
        end
        if (done_w[d] != 2'b00) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", done_w[d], 0);
          end else begin
            mon_e = sbq.pop_front();
            chk("done_owner", done_w[d], mon_e.owner ? 2'b10 : 2'b01);
            chk("busy_cycles", busy_cnt[d], busy_total(d));
            chk("strobe_cycles", strobe_cnt[d], strobe_len(d));
            if (!mon_e.we) last_rd[d] = mon_e.sdin;
            chk("rdata", rdata_w[d], last_rd[d]);
          end
          busy_cnt[d]   = 0;
          strobe_cnt[d] = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 2'b00; we_v[d] = 2'b00; a0_v[d] = '0; a1_v[d] = '0;
      w0_v[d] = '0; w1_v[d] = '0; sdin_v[d] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    // single write from requester 0
    set_req(0, 0, 1'b1, 10'h2B0, 8'h5A);
    push_exp(0, 0, 1'b1, 10'h2B0, 8'h5A, 8'h00);
    wait_done(0, 5, seen);
    req_v[0] = 2'b00;
    @(negedge clk);

    // single read from requester 1
    sdin_v[0] = 8'hC3;
    set_req(0, 1, 1'b0, 10'h2B1, 8'h00);
    push_exp(0, 1, 1'b0, 10'h2B1, 8'h00, 8'hC3);
    wait_done(0, 5, seen);
    req_v[0] = 2'b00;
    @(negedge clk);

    // both held: requester 1 won last, so 0,1,0,1
    sdin_v[0] = 8'h3C;
    set_req(0, 0, 1'b1, 10'h120, 8'hA5);
    set_req(0, 1, 1'b0, 10'h121, 8'h00);
    for (int k = 0; k < 4; k++)
      push_exp(0, k % 2, (k % 2) == 0, (k % 2) ? 10'h121 : 10'h120,
               (k % 2) ? 8'h00 : 8'hA5, 8'h3C);
    wait_done(0, 5, seen);
    for (int k = 0; k < 3; k++) wait_done(0, 6, seen);
    req_v[0] = 2'b00;
    @(negedge clk);

    // requester inputs change and req drops during STROBE
    set_req(0, 0, 1'b1, 10'h2B0, 8'h96);
    push_exp(0, 0, 1'b1, 10'h2B0, 8'h96, 8'h00);
    wait_strobe(0);
    a0_v[0] = 10'h3FF; w0_v[0] = 8'hFF; we_v[0][0] = 1'b0; req_v[0] = 2'b00;
    wait_done(0, 3, seen);
    @(negedge clk);

    // reset in the middle of a write strobe abandons it
    set_req(0, 0, 1'b1, 10'h300, 8'h11);
    push_exp(0, 0, 1'b1, 10'h300, 8'h11, 8'h00);
    wait_strobe(0);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    void'(sbq.pop_front());
    req_v[0] = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sdin_v[0] = 8'h77;
    set_req(0, 1, 1'b0, 10'h302, 8'h00);
    push_exp(0, 1, 1'b0, 10'h302, 8'h00, 8'h77);
    wait_done(0, 5, seen);
    req_v[0] = 2'b00;
    @(negedge clk);

    // 2/1/3 timing copy: fresh pointer favours requester 0
    sdin_v[1] = 8'hC3;
    set_req(1, 0, 1'b1, 10'h2B0, 8'h5A);
    set_req(1, 1, 1'b0, 10'h2B1, 8'h00);
    push_exp(1, 0, 1'b1, 10'h2B0, 8'h5A, 8'h00);
    push_exp(1, 1, 1'b0, 10'h2B1, 8'h00, 8'hC3);
    wait_done(1, 6, seen);
    req_v[1][0] = 1'b0;
    wait_done(1, 7, seen);
    req_v[1] = 2'b00;

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
